// File: rtl/scan_sel_gen_pkg.sv
// Shared types and constants for the scan select generator: FSM state type,
// address width, position count and the address step helpers.
package scan_sel_gen_pkg;

    localparam int AddrW  = 3;
    localparam int NumPos = 8;
    localparam int CntW   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } scanState_e;

    function automatic logic [AddrW-1:0] stepAddr(input logic [AddrW-1:0] addr,
                                                  input logic             down);
        return down ? (addr - AddrW'(1)) : (addr + AddrW'(1));
    endfunction

    // True when the step from addr in the given direction crosses the sweep boundary.
    function automatic logic isWrapStep(input logic [AddrW-1:0] addr,
                                        input logic             down);
        return down ? (addr == '0) : (addr == AddrW'(NumPos - 1));
    endfunction

endpackage

// File: rtl/scan_tick_cnt.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
// Used for both the dwell and the gap timing of the scan generator.
module scan_tick_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over load so an abort never leaves a stale count behind.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = loadVal_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/scan_sel_gen.sv
// Scan select generator: steps a 3-bit decoder address through 8 positions,
// holding the enable high for DWELL cycles and low for BLANK cycles per position.
module scan_sel_gen
    import scan_sel_gen_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             dir,
    input  logic             single,
    output logic [AddrW-1:0] a,
    output logic             e,
    output logic             wrap,
    output logic             busy
);

    localparam logic [CntW-1:0]  DwellLoad = CntW'(DWELL - 1);
    localparam logic [CntW-1:0]  GapLoad   = (BLANK > 0) ? CntW'(BLANK - 1) : '0;
    localparam bit               HasGap    = (BLANK > 0);
    localparam logic [AddrW-1:0] LastPos   = AddrW'(NumPos - 1);

    scanState_e       state_q;
    scanState_e       state_d;
    logic [AddrW-1:0] a_q;
    logic [AddrW-1:0] a_d;
    logic [AddrW-1:0] pos_q;
    logic [AddrW-1:0] pos_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             e_q;
    logic             e_d;
    logic             busy_q;
    logic             busy_d;
    logic             runArm_q;
    logic             runArm_d;
    logic             dwellLoad;
    logic             gapLoad;
    logic             cntClear;
    logic             dwellDone;
    logic             gapDone;
    logic             advance;

    scan_tick_cnt #(.W(CntW)) u_dwell_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cntClear),
        .load_i    (dwellLoad),
        .loadVal_i (DwellLoad),
        .done_o    (dwellDone)
    );

    scan_tick_cnt #(.W(CntW)) u_gap_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cntClear),
        .load_i    (gapLoad),
        .loadVal_i (GapLoad),
        .done_o    (gapDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
        end
    end

    // runArm only becomes set after run is seen low, so a run already high
    // at reset release or after a single sweep never starts a new sweep.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        pos_d     = pos_q;
        wrap_d    = 1'b0;
        runArm_d  = ~run;
        dwellLoad = 1'b0;
        gapLoad   = 1'b0;
        cntClear  = 1'b0;
        advance   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run && runArm_q) begin
                    state_d   = ACTIVE;
                    a_d       = dir ? LastPos : '0;
                    pos_d     = '0;
                    dwellLoad = 1'b1;
                end
            end
            ACTIVE: begin
                if (!run) begin
                    state_d  = IDLE;
                    cntClear = 1'b1;
                end else if (dwellDone) begin
                    if (HasGap) begin
                        state_d = GAP;
                        gapLoad = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!run) begin
                    state_d  = IDLE;
                    cntClear = 1'b1;
                end else if (gapDone) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cntClear = 1'b1;
            end
        endcase

        if (advance) begin
            if (single && (pos_q == LastPos)) begin
                state_d  = IDLE;
                wrap_d   = 1'b1;
                cntClear = 1'b1;
            end else begin
                state_d   = ACTIVE;
                a_d       = stepAddr(a_q, dir);
                wrap_d    = isWrapStep(a_q, dir);
                pos_d     = pos_q + AddrW'(1);
                dwellLoad = 1'b1;
            end
        end
    end

    always_comb begin
        e_d    = (state_d == ACTIVE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            pos_q    <= '0;
            wrap_q   <= 1'b0;
            runArm_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            pos_q    <= pos_d;
            wrap_q   <= wrap_d;
            runArm_q <= runArm_d;
        end
    end

    assign a    = a_q;
    assign e    = e_q;
    assign wrap = wrap_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed self-checking bench for scan_sel_gen: one instance with DWELL=4/BLANK=1
// and one with DWELL=2/BLANK=0, driven with hand-computed expected sequences.
module tb_scan_sel_gen;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       dir;
    logic       single;
    logic [2:0] a;
    logic       e;
    logic       wrap;
    logic       busy;

    logic       run2;
    logic       dir2;
    logic       single2;
    logic [2:0] a2;
    logic       e2;
    logic       wrap2;
    logic       busy2;

    int checkCount;
    int passCount;

    scan_sel_gen #(.DWELL(4), .BLANK(1)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .dir    (dir),
        .single (single),
        .a      (a),
        .e      (e),
        .wrap   (wrap),
        .busy   (busy)
    );

    scan_sel_gen #(.DWELL(2), .BLANK(0)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run2),
        .dir    (dir2),
        .single (single2),
        .a      (a2),
        .e      (e2),
        .wrap   (wrap2),
        .busy   (busy2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic d, input logic s);
        run    = r;
        dir    = d;
        single = s;
    endtask

    // Sampling point sits 1 time unit after each rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected behaviour of the DWELL=4/BLANK=1 instance counting up:
    // cycle k after the start edge is position k/5, phase k%5 (phase 4 is the gap).
    task automatic checkUpWindow(input int kFrom, input int kTo);
        for (int k = kFrom; k <= kTo; k++) begin
            int p;
            int r;
            p = k / 5;
            r = k % 5;
            checkOutput($sformatf("up a k=%0d", k), a, p % 8);
            checkOutput($sformatf("up e k=%0d", k), e, (r < 4) ? 1 : 0);
            checkOutput($sformatf("up wrap k=%0d", k), wrap,
                        (r == 0 && k > 0 && (p % 8) == 0) ? 1 : 0);
            checkOutput($sformatf("up busy k=%0d", k), busy, 1);
            if (k < kTo) stepCycle();
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        run2    = 1'b0;
        dir2    = 1'b0;
        single2 = 1'b0;

        #2;
        checkOutput("reset a", a, 0);
        checkOutput("reset e", e, 0);
        checkOutput("reset wrap", wrap, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset a2", a2, 0);
        checkOutput("reset busy2", busy2, 0);

        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("idle busy", busy, 0);
        checkOutput("idle e", e, 0);

        // Continuous up sweep, past one wrap, then stop at position 1.
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        checkUpWindow(0, 46);
        run = 1'b0;
        stepCycle();
        checkOutput("stop a", a, 1);
        checkOutput("stop e", e, 0);
        checkOutput("stop busy", busy, 0);
        checkOutput("stop wrap", wrap, 0);

        // Stop during the dwell of position 3.
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        checkUpWindow(0, 16);
        run = 1'b0;
        stepCycle();
        checkOutput("drop a", a, 3);
        checkOutput("drop e", e, 0);
        checkOutput("drop busy", busy, 0);
        checkOutput("drop wrap", wrap, 0);
        stepCycle();
        checkOutput("drop wrap later", wrap, 0);
        checkOutput("drop busy later", busy, 0);

        // Direction flipped during the dwell of position 5.
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        checkUpWindow(0, 25);
        dir = 1'b1;
        repeat (4) stepCycle();
        checkOutput("flip gap a", a, 5);
        checkOutput("flip gap e", e, 0);
        stepCycle();
        checkOutput("flip next a", a, 4);
        checkOutput("flip next e", e, 1);
        checkOutput("flip next wrap", wrap, 0);
        repeat (5) stepCycle();
        checkOutput("flip after a", a, 3);
        run = 1'b0;
        stepCycle();

        // Single sweep with run held high.
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycle();
        checkUpWindow(0, 39);
        stepCycle();
        checkOutput("single end wrap", wrap, 1);
        checkOutput("single end busy", busy, 0);
        checkOutput("single end e", e, 0);
        checkOutput("single end a", a, 7);
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput($sformatf("single hold wrap %0d", i), wrap, 0);
            checkOutput($sformatf("single hold busy %0d", i), busy, 0);
            checkOutput($sformatf("single hold a %0d", i), a, 7);
        end
        run = 1'b0;
        stepCycle();
        run = 1'b1;
        stepCycle();
        checkOutput("single restart a", a, 0);
        checkOutput("single restart busy", busy, 1);
        checkOutput("single restart e", e, 1);

        // Asynchronous reset in the gap after position 1.
        repeat (9) stepCycle();
        checkOutput("pre-reset a", a, 1);
        checkOutput("pre-reset e", e, 0);
        checkOutput("pre-reset busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset a", a, 0);
        checkOutput("async reset e", e, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset wrap", wrap, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput($sformatf("post-reset busy %0d", i), busy, 0);
            checkOutput($sformatf("post-reset e %0d", i), e, 0);
        end
        run = 1'b0;
        stepCycle();
        run = 1'b1;
        stepCycle();
        checkOutput("post-reset start busy", busy, 1);
        checkOutput("post-reset start a", a, 0);
        checkOutput("post-reset start e", e, 1);
        run = 1'b0;
        stepCycle();

        // No-gap instance sweeping down: e stays high, wrap on 0->7.
        dir2 = 1'b1;
        run2 = 1'b1;
        stepCycle();
        for (int k = 0; k < 20; k++) begin
            int p;
            p = k / 2;
            checkOutput($sformatf("down a2 k=%0d", k), a2, (7 - p) & 7);
            checkOutput($sformatf("down e2 k=%0d", k), e2, 1);
            checkOutput($sformatf("down wrap2 k=%0d", k), wrap2,
                        ((k % 2) == 0 && k > 0 && (p % 8) == 0) ? 1 : 0);
            checkOutput($sformatf("down busy2 k=%0d", k), busy2, 1);
            stepCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 Parameter DWELL, default 4: cycles e is held high per address position; legal range 1..255.
REQ-002 Parameter BLANK, default 1: cycles e is held low between positions; legal range 0..255.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 run  input  1  level; 1 = scanning enabled, 0 = stop.
REQ-006 dir  input  1  0 = count up (0->7), 1 = count down (7->0).
REQ-007 single  input  1  1 = one sweep of 8 positions, then stop; 0 = continuous.
REQ-008 a  output  3  select address for the downstream 3-to-8 decoder, registered.
REQ-009 e  output  1  decoder enable, registered; high only during the dwell window.
REQ-010 wrap  output  1  one-cycle pulse, registered, when a sweep of 8 positions completes.
REQ-011 busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-012 FSM states: IDLE, ACTIVE, GAP; state encoding is internal.
REQ-013 IDLE: e=0, busy=0, a holds its value; on run=1 -> ACTIVE next cycle, a loaded with 0 (dir=0) or 7 (dir=1).
REQ-014 ACTIVE: e=1 for exactly DWELL consecutive cycles per position, counted by an 8-bit dwell counter.
REQ-015 End of dwell with BLANK>0 -> GAP: e=0 for exactly BLANK cycles; a is unchanged during GAP; then a advances and the FSM re-enters ACTIVE.
REQ-016 End of dwell with BLANK=0 -> a advances on the same edge and the FSM stays in ACTIVE; e stays high continuously.
REQ-017 Advance: a+1 modulo 8 (dir=0) or a-1 modulo 8 (dir=1); dir is sampled only at the advance edge; a mid-sweep dir change reverses from the current position.
REQ-018 wrap=1 for one cycle, coincident with the advance edge, when a goes 7->0 (up) or 0->7 (down).
REQ-019 single=1: once the eighth position's dwell (plus its GAP, if any) completes, wrap pulses, the FSM -> IDLE and a holds its last value; single is sampled at that edge.
REQ-020 In single mode, run must drop to 0 and return to 1 before a new sweep starts; in IDLE, a new sweep starts only on a 0->1 edge of run.
REQ-021 run=0 sampled in ACTIVE or GAP -> IDLE on the next edge: e=0, counters cleared, a holds, no wrap pulse.
REQ-022 The address a and enable e change only on clock edges; no combinational path exists from inputs to outputs.
REQ-023 The period of one position is DWELL+BLANK cycles; a full continuous sweep takes 8*(DWELL+BLANK) cycles.

Reset
REQ-024 rst_n=0 forces asynchronously: state=IDLE, a=3'b000, e=0, wrap=0, busy=0, dwell and gap counters=0, run-edge register=0.
REQ-025 Reset asserted mid-sweep aborts it immediately.
REQ-026 After rst_n deasserts, the first sweep starts only on a run 0->1 edge; a run already high at reset release is not a start.

Structure
REQ-027 The shared package holds the state enumeration type and the address width constant (3) and position count (8).
REQ-028 One sub-module, scan_tick_cnt, a loadable down-counter, is used for both the dwell and the gap timing.
REQ-029 No other sub-modules; the decoder itself is not instantiated inside this block.

Verification
REQ-030 DWELL=4, BLANK=1, dir=0, single=0, run rises -> a=0,1,..,7,0 with e high 4 cycles and low 1 cycle per position; wrap pulses once per 40 cycles.
REQ-031 DWELL=2, BLANK=0, dir=1 -> a=7,6,..,0,7 with e continuously 1; wrap pulses at the 0->7 edge.
REQ-032 single=1, run held high -> exactly 8 positions, wrap once, then busy=0, e=0, a=7; no restart until run toggles.
REQ-033 run dropped during dwell of position 3 -> next cycle e=0, busy=0, a=3, no wrap.
REQ-034 dir flipped from 0 to 1 during dwell of position 5 -> next position is a=4.
REQ-035 rst_n pulsed low mid-GAP (asynchronous to clk) -> outputs reach reset values before the next edge; with run held high, no restart until run toggles.
